// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six-state one-hot ring counter (T1..T6) plus instruction decoder
// producing the per-cycle control word for PC, MAR, RAM, IR, A, B, ALU and output register.
module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       pc_inc,
    output logic       pc_enable,
    output logic       mar_load,
    output logic       ram_enable,
    output logic       ir_load,
    output logic       ir_enable,
    output logic       a_load,
    output logic       a_enable,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_enable,
    output logic       out_load,
    output logic       halt
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] t_state_q;
    logic [5:0] t_state_d;
    logic [5:0] ring_rot;
    logic       halt_q;
    logic       halt_d;

    // Left rotation of the ring: T6 wraps back into T1.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_rot
            assign ring_rot[gi] = t_state_q[(gi + 5) % 6];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            t_state_q <= T1;
            halt_q    <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halt_q    <= halt_d;
        end
    end

    // Next-state logic; a corrupted ring recovers to T1 even while halted.
    always_comb begin
        t_state_d = ring_rot;
        halt_d    = halt_q;
        if (!$onehot(t_state_q)) begin
            t_state_d = T1;
        end else if (halt_q) begin
            t_state_d = t_state_q;
        end else if ((t_state_q == T4) && (opcode == OP_HLT)) begin
            t_state_d = T4;
            halt_d    = 1'b1;
        end
    end

    // Output decode. HLT's own T4 and every halted cycle leave all controls low.
    always_comb begin
        pc_inc     = 1'b0;
        pc_enable  = 1'b0;
        mar_load   = 1'b0;
        ram_enable = 1'b0;
        ir_load    = 1'b0;
        ir_enable  = 1'b0;
        a_load     = 1'b0;
        a_enable   = 1'b0;
        b_load     = 1'b0;
        alu_sub    = 1'b0;
        alu_enable = 1'b0;
        out_load   = 1'b0;
        if (!halt_q) begin
            case (t_state_q)
                T1: begin
                    pc_enable = 1'b1;
                    mar_load  = 1'b1;
                end
                T2: begin
                    pc_inc = 1'b1;
                end
                T3: begin
                    ram_enable = 1'b1;
                    ir_load    = 1'b1;
                end
                T4: begin
                    if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ir_enable = 1'b1;
                        mar_load  = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        a_enable = 1'b1;
                        out_load = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_enable = 1'b1;
                        a_load     = 1'b1;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ram_enable = 1'b1;
                        b_load     = 1'b1;
                    end
                end
                T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        alu_enable = 1'b1;
                        a_load     = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign t_state = t_state_q;
    assign halt    = halt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: stimulus queues expected control words,
// a monitor on the falling edge pops and compares them and checks the bus invariant.
module tb_controller_sequencer;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [3:0] OP_NOP = 4'b0101;

    localparam logic [11:0] PC_INC  = 12'h800;
    localparam logic [11:0] PC_EN   = 12'h400;
    localparam logic [11:0] MAR_LD  = 12'h200;
    localparam logic [11:0] RAM_EN  = 12'h100;
    localparam logic [11:0] IR_LD   = 12'h080;
    localparam logic [11:0] IR_EN   = 12'h040;
    localparam logic [11:0] A_LD    = 12'h020;
    localparam logic [11:0] A_EN    = 12'h010;
    localparam logic [11:0] B_LD    = 12'h008;
    localparam logic [11:0] ALU_SUB = 12'h004;
    localparam logic [11:0] ALU_EN  = 12'h002;
    localparam logic [11:0] OUT_LD  = 12'h001;
    localparam logic [11:0] NONE    = 12'h000;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct {
        bit          chk;
        logic [5:0]  ts;
        logic        hl;
        logic [11:0] cw;
        string       tag;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
    logic       a_load, a_enable, b_load, alu_sub, alu_enable, out_load, halt;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    controller_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .t_state   (t_state),
        .pc_inc    (pc_inc),
        .pc_enable (pc_enable),
        .mar_load  (mar_load),
        .ram_enable(ram_enable),
        .ir_load   (ir_load),
        .ir_enable (ir_enable),
        .a_load    (a_load),
        .a_enable  (a_enable),
        .b_load    (b_load),
        .alu_sub   (alu_sub),
        .alu_enable(alu_enable),
        .out_load  (out_load),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs set just after a rising edge; the expected entry describes the outputs
    // seen before the next rising edge (registered state plus these inputs).
    task automatic drive(input logic rst, input logic [3:0] op, input logic [5:0] ts,
                         input logic hl, input logic [11:0] cw, input bit chk, input string tag);
        exp_t e;
        @(posedge clk);
        #2;
        reset  = rst;
        opcode = op;
        e.chk = chk;
        e.ts  = ts;
        e.hl  = hl;
        e.cw  = cw;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Fetch states are opcode-independent; fetch_op lets a test prove that.
    task automatic instr(input logic [3:0] fetch_op, input logic [3:0] op,
                         input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6,
                         input string tag);
        drive(1'b0, fetch_op, T1, 1'b0, PC_EN | MAR_LD, 1'b1, {tag, "_t1"});
        drive(1'b0, fetch_op, T2, 1'b0, PC_INC,         1'b1, {tag, "_t2"});
        drive(1'b0, fetch_op, T3, 1'b0, RAM_EN | IR_LD, 1'b1, {tag, "_t3"});
        drive(1'b0, op,       T4, 1'b0, c4,             1'b1, {tag, "_t4"});
        drive(1'b0, op,       T5, 1'b0, c5,             1'b1, {tag, "_t5"});
        drive(1'b0, op,       T6, 1'b0, c6,             1'b1, {tag, "_t6"});
    endtask

    // Monitor: every cycle with a pending entry is one vector.
    initial begin
        exp_t        e;
        logic [11:0] cw_act;
        int          drivers;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cw_act = {pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
                          a_load, a_enable, b_load, alu_sub, alu_enable, out_load};
                drivers = int'(pc_enable) + int'(ram_enable) + int'(ir_enable)
                        + int'(a_enable) + int'(alu_enable);
                vectors++;
                if (e.chk && ((t_state !== e.ts) || (halt !== e.hl) || (cw_act !== e.cw))) begin
                    miscompares++;
                    $display("FAIL %s: got ts=%b halt=%b cw=%h, want ts=%b halt=%b cw=%h",
                             e.tag, t_state, halt, cw_act, e.ts, e.hl, e.cw);
                end else if (!$onehot(t_state) || (drivers > 1)) begin
                    miscompares++;
                    $display("FAIL %s_invariant: got ts=%b drivers=%0d, want one-hot ts and drivers<=1",
                             e.tag, t_state, drivers);
                end else begin
                    $display("vec %0d %s ts=%b halt=%b cw=%h", vectors, e.tag, t_state, halt, cw_act);
                end
            end
        end
    end

    initial begin
        int         guard;
        logic [3:0] rop;
        reset  = 1'b1;
        opcode = OP_LDA;

        // Reset held for two cycles
        drive(1'b1, OP_LDA, T1, 1'b0, PC_EN | MAR_LD, 1'b1, "reset0");
        drive(1'b1, OP_LDA, T1, 1'b0, PC_EN | MAR_LD, 1'b1, "reset1");

        instr(OP_LDA, OP_LDA, IR_EN | MAR_LD, RAM_EN | A_LD, NONE, "lda");
        instr(OP_SUB, OP_SUB, IR_EN | MAR_LD, RAM_EN | B_LD, ALU_EN | A_LD | ALU_SUB, "sub");
        instr(OP_HLT, OP_ADD, IR_EN | MAR_LD, RAM_EN | B_LD, ALU_EN | A_LD, "add_fetch_hlt");
        instr(OP_OUT, OP_OUT, A_EN | OUT_LD, NONE, NONE, "out");
        instr(OP_NOP, OP_NOP, NONE, NONE, NONE, "nop");

        // Reset in the middle of an ADD (during T5)
        drive(1'b0, OP_ADD, T1, 1'b0, PC_EN | MAR_LD, 1'b1, "addrst_t1");
        drive(1'b0, OP_ADD, T2, 1'b0, PC_INC,         1'b1, "addrst_t2");
        drive(1'b0, OP_ADD, T3, 1'b0, RAM_EN | IR_LD, 1'b1, "addrst_t3");
        drive(1'b0, OP_ADD, T4, 1'b0, IR_EN | MAR_LD, 1'b1, "addrst_t4");
        drive(1'b1, OP_ADD, T5, 1'b0, RAM_EN | B_LD,  1'b1, "addrst_t5");
        drive(1'b0, OP_ADD, T1, 1'b0, PC_EN | MAR_LD, 1'b1, "addrst_after");

        // HLT: T4 itself is silent, then frozen at T4 with halt set
        drive(1'b0, OP_HLT, T2, 1'b0, PC_INC,         1'b1, "hlt_t2");
        drive(1'b0, OP_HLT, T3, 1'b0, RAM_EN | IR_LD, 1'b1, "hlt_t3");
        drive(1'b0, OP_HLT, T4, 1'b0, NONE,           1'b1, "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, (i % 2 == 0) ? OP_LDA : OP_OUT, T4, 1'b1, NONE, 1'b1, "halted");
        end
        drive(1'b1, OP_LDA, T4, 1'b1, NONE,           1'b1, "halted_rst");
        drive(1'b0, OP_LDA, T1, 1'b0, PC_EN | MAR_LD, 1'b1, "unhalt_t1");
        drive(1'b0, OP_LDA, T2, 1'b0, PC_INC,         1'b1, "unhalt_t2");

        // Free run with random opcodes: only the invariants are checked
        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(15));
            drive(1'b0, rop, T1, 1'b0, NONE, 1'b0, "random");
        end
        drive(1'b1, OP_LDA, T1, 1'b0, NONE,           1'b0, "final_rst");
        drive(1'b0, OP_LDA, T1, 1'b0, PC_EN | MAR_LD, 1'b1, "final_t1");

        guard = 0;
        while ((sb.size() > 0) && (guard < 20)) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
